elastic_reg: RTL and testbench

- Parametrised successor to the single-stage enable/reset pipeline register.
- A DEPTH-entry elastic pipeline buffer with valid/ready handshakes on both sides, a synchronous flush and a defined output when empty.
- Sits between BRISC pipeline stages (e.g. IF/ID, ID/EX, memory-response path) so that back-pressure and squashes are absorbed locally, not through global enables.

---
 rtl/brisc_pkg.sv | 12 +
 rtl/elastic_reg_ctrl.sv | 80 ++++++++
 rtl/elastic_reg.sv | 64 ++++++
 tb/tb_elastic_reg.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/brisc_pkg.sv
// Shared BRISC constants and helpers used by
// the pipeline stages and the elastic buffers.
package brisc_pkg;

  localparam int XLEN = 32;
  localparam int ELASTIC_DEFAULT_DEPTH = 2;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/elastic_reg_ctrl.sv
// Pointer, occupancy and handshake control for an elastic buffer.
// ELASTIC_REG_BYPASS_EN enables the empty-buffer fall-through path.
module elastic_reg_ctrl
  import brisc_pkg::*;
#(
  parameter int DEPTH = ELASTIC_DEFAULT_DEPTH,
  localparam int PW = ptr_w(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic          in_ready,
  output logic          out_valid,
  output logic          wr_en,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count
);

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic byp_take;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full;

`ifdef ELASTIC_REG_BYPASS_EN
  // Empty buffer lets a beat fall straight through to the consumer.
  assign out_valid = !empty | (!flush & in_valid);
  assign byp_take  = empty & !flush & in_valid & out_ready;
`else
  assign out_valid = !empty;
  assign byp_take  = 1'b0;
`endif

  assign push  = in_valid & in_ready & !byp_take;
  assign pop   = !empty & out_ready;
  assign wr_en = push & !flush;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (count <= CW'(DEPTH));
      assert (!(push && full));
      assert (!(pop && empty));
    end
  end
`endif

endmodule

// File: rtl/elastic_reg.sv
// DEPTH-entry elastic pipeline buffer with flush and defined empty output.
// ELASTIC_REG_BYPASS_EN adds a zero-latency path when the buffer is empty.
module elastic_reg
  import brisc_pkg::*;
#(
  parameter int               WIDTH       = XLEN,
  parameter int               DEPTH       = ELASTIC_DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = ptr_w(DEPTH);

  logic             wr_en;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  elastic_reg_ctrl #(
    .DEPTH(DEPTH)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .wr_en    (wr_en),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VALUE;
    end else if (wr_en) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_comb begin
    out_data = RESET_VALUE;
    if (count != '0) begin
      out_data = mem[rd_ptr];
`ifdef ELASTIC_REG_BYPASS_EN
    end else if (!flush && in_valid) begin
      out_data = in_data;
`endif
    end
  end

endmodule

// File: tb/tb_elastic_reg.sv
// Self-checking bench for elastic_reg: queue model per instance
// (DEPTH=2 and DEPTH=3) plus directed literal checks.
module tb_elastic_reg;

`ifdef ELASTIC_REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [15:0] RV2 = 16'hDEAD;
  localparam logic [15:0] RV3 = 16'hBEEF;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_data;

  logic        rdy2, val2, rdy3, val3;
  logic [15:0] dat2, dat3;
  logic [1:0]  cnt2, cnt3;

  int vectors;
  int miscompares;

  logic [15:0] q2[$];
  logic [15:0] q3[$];
  bit byp2, pop2, push2, byp3, pop3, push3;

  elastic_reg #(
    .WIDTH(16), .DEPTH(2), .RESET_VALUE(RV2)
  ) u2 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
    .out_valid(val2), .out_ready(out_ready), .out_data(dat2),
    .count(cnt2)
  );

  elastic_reg #(
    .WIDTH(16), .DEPTH(3), .RESET_VALUE(RV3)
  ) u3 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy3), .in_data(in_data),
    .out_valid(val3), .out_ready(out_ready), .out_data(dat3),
    .count(cnt3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // Queue models: a FIFO of at most DEPTH items; flush/reset empty it.
  always @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      q2.delete();
    end else begin
      byp2  = BYP && q2.size() == 0 && in_valid && out_ready;
      pop2  = q2.size() > 0 && out_ready;
      push2 = in_valid && q2.size() < 2 && !byp2;
      if (pop2)  void'(q2.pop_front());
      if (push2) q2.push_back(in_data);
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      q3.delete();
    end else begin
      byp3  = BYP && q3.size() == 0 && in_valid && out_ready;
      pop3  = q3.size() > 0 && out_ready;
      push3 = in_valid && q3.size() < 3 && !byp3;
      if (pop3)  void'(q3.pop_front());
      if (push3) q3.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    logic fall;
    fall = BYP && !flush && in_valid;
    chk("u2.count", 32'(cnt2), 32'(q2.size()));
    chk("u2.in_ready", 32'(rdy2), 32'(q2.size() < 2));
    chk("u2.out_valid", 32'(val2), 32'(q2.size() > 0 || fall));
    chk("u2.out_data", 32'(dat2),
        32'((q2.size() > 0) ? q2[0] : (fall ? in_data : RV2)));
    chk("u3.count", 32'(cnt3), 32'(q3.size()));
    chk("u3.in_ready", 32'(rdy3), 32'(q3.size() < 3));
    chk("u3.out_valid", 32'(val3), 32'(q3.size() > 0 || fall));
    chk("u3.out_data", 32'(dat3),
        32'((q3.size() > 0) ? q3[0] : (fall ? in_data : RV3)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d,
                       input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    drive(0, 16'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(val2), 32'h0);
    chk("rst.out_data", 32'(dat2), 32'hDEAD);
    chk("rst.in_ready", 32'(rdy2), 32'h1);
    chk("rst.count", 32'(cnt2), 32'h0);
    reset = 1'b0;
    tick();

    // Fill and hold
    drive(1, 16'h11, 0, 0); tick();
    drive(1, 16'h22, 0, 0); tick();
    drive(1, 16'h33, 0, 0); tick();
    drive(1, 16'h44, 0, 0); tick();
    drive(0, 16'h0, 1, 0);
    #1;
    chk("fill.u3.count", 32'(cnt3), 32'h3);
    chk("fill.u3.in_ready", 32'(rdy3), 32'h0);
    chk("fill.u2.count", 32'(cnt2), 32'h2);
    chk("drain.u3.d0", 32'(dat3), 32'h11);
    tick();
    chk("drain.u3.d1", 32'(dat3), 32'h22);
    tick();
    chk("drain.u3.d2", 32'(dat3), 32'h33);
    tick();
    chk("drain.u3.empty", 32'(val3), 32'h0);
    chk("drain.u3.rv", 32'(dat3), 32'hBEEF);

    // Streaming 1..10
    for (int i = 1; i <= 10; i++) begin
      drive(1, 16'(i), 1, 0);
      tick();
`ifndef ELASTIC_REG_BYPASS_EN
      chk("stream.u2.data", 32'(dat2), 32'(i));
      chk("stream.u2.count", 32'(cnt2), 32'h1);
      chk("stream.u3.data", 32'(dat3), 32'(i));
`else
      chk("stream.u2.count", 32'(cnt2), 32'h0);
`endif
    end
    drive(0, 16'h0, 1, 0);
    tick();
    tick();

    // Asynchronous reset with two entries held
    drive(1, 16'hA1, 0, 0); tick();
    drive(1, 16'hA2, 0, 0); tick();
    drive(0, 16'h0, 0, 0);
    chk("pre_rst.u2.count", 32'(cnt2), 32'h2);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst.out_valid", 32'(val2), 32'h0);
    chk("mid_rst.count", 32'(cnt2), 32'h0);
    chk("mid_rst.in_ready", 32'(rdy2), 32'h1);
    chk("mid_rst.out_data", 32'(dat2), 32'hDEAD);
    #1 reset = 1'b0;
    tick();

    // Flush beats simultaneous push and pop
    drive(1, 16'hB1, 0, 0); tick();
    drive(1, 16'hB2, 0, 0); tick();
    chk("pre_flush.u2.count", 32'(cnt2), 32'h2);
    drive(1, 16'h55, 1, 1); tick();
    drive(0, 16'h0, 1, 0);
    chk("flush.u2.count", 32'(cnt2), 32'h0);
    chk("flush.u2.out_valid", 32'(val2), 32'h0);
    chk("flush.u2.out_data", 32'(dat2), 32'hDEAD);
    chk("flush.u3.count", 32'(cnt3), 32'h0);
    repeat (3) tick();

    // Full plus pop: pop happens, push is refused
    drive(1, 16'hC1, 0, 0); tick();
    drive(1, 16'hC2, 0, 0); tick();
    drive(1, 16'hC3, 1, 0);
    chk("full.u2.in_ready", 32'(rdy2), 32'h0);
    chk("full.u2.out_data", 32'(dat2), 32'hC1);
    tick();
    drive(0, 16'h0, 0, 0);
    chk("fullpop.u2.in_ready", 32'(rdy2), 32'h1);
    chk("fullpop.u2.count", 32'(cnt2), 32'h1);
    chk("fullpop.u2.out_data", 32'(dat2), 32'hC2);
    chk("fullpop.u3.count", 32'(cnt3), 32'h2);
    drive(0, 16'h0, 1, 0);
    repeat (3) tick();

    // Empty buffer, single beat with consumer ready
    drive(1, 16'h7, 1, 0);
    #1;
`ifdef ELASTIC_REG_BYPASS_EN
    chk("byp.out_valid", 32'(val2), 32'h1);
    chk("byp.out_data", 32'(dat2), 32'h7);
    chk("byp.count", 32'(cnt2), 32'h0);
`else
    chk("lat.out_valid0", 32'(val2), 32'h0);
`endif
    tick();
    drive(0, 16'h0, 1, 0);
`ifdef ELASTIC_REG_BYPASS_EN
    chk("byp.after_valid", 32'(val2), 32'h0);
    chk("byp.after_count", 32'(cnt2), 32'h0);
`else
    chk("lat.out_valid1", 32'(val2), 32'h1);
    chk("lat.out_data1", 32'(dat2), 32'h7);
`endif
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
